cic_comb_chain: RTL

Parametrised CIC comb section. It cascades `STAGES` comb stages, each computing y[n] = x[n] − x[n−DIFF_DELAY], and keeps separate history for up to `CHANNELS` time-multiplexed channels. It sits after the decimator in the CIC chain and replaces the single-stage, single-channel, unit-delay comb. Every stage is registered, and a valid/channel tag travels down the pipeline with the data.

---
 rtl/cic_comb_chain.sv | 112 +++++++++++
 1 files changed

// File: rtl/cic_comb_chain.sv
// Multi-stage, multi-channel CIC comb: (1 - z^-M)^N per channel, one register per stage.
// A valid bit and channel tag travel alongside the data through every stage.

module cic_comb_stage #(
  parameter int WIDTH      = 16,
  parameter int DIFF_DELAY = 1,
  parameter int CHANNELS   = 1,
  parameter int CHW        = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [CHW-1:0]   i_chan,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [CHW-1:0]   o_chan,
  output logic [WIDTH-1:0] o_data
);
  localparam logic [CHW:0] CH_LIM = (CHW+1)'(CHANNELS);

  // hist[c][0] is the newest sample of channel c, hist[c][DIFF_DELAY-1] the oldest
  logic [CHANNELS-1:0][DIFF_DELAY-1:0][WIDTH-1:0] hist_q, hist_d;
  logic             vld_q, vld_d;
  logic [CHW-1:0]   chan_q, chan_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             acc;
  logic [WIDTH-1:0] oldest;

  always_comb begin
    acc    = i_valid && ({1'b0, i_chan} < CH_LIM);
    oldest = '0;
    hist_d = hist_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (i_chan == CHW'(c)) begin
        oldest = hist_q[c][DIFF_DELAY-1];
        if (acc) begin
          for (int j = DIFF_DELAY-1; j > 0; j--) hist_d[c][j] = hist_q[c][j-1];
          hist_d[c][0] = i_data;
        end
      end
    end
    vld_d  = acc;
    chan_d = acc ? i_chan : chan_q;
    // modulo 2^WIDTH on purpose: integrator wrap cancels here
    data_d = acc ? i_data - oldest : data_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hist_q <= '0;
      vld_q  <= 1'b0;
      chan_q <= '0;
      data_q <= '0;
    end else if (i_en) begin
      hist_q <= hist_d;
      vld_q  <= vld_d;
      chan_q <= chan_d;
      data_q <= data_d;
    end
  end

  assign o_valid = vld_q;
  assign o_chan  = chan_q;
  assign o_data  = data_q;
endmodule

module cic_comb_chain #(
  parameter  int WIDTH      = 16,
  parameter  int STAGES     = 3,
  parameter  int DIFF_DELAY = 1,
  parameter  int CHANNELS   = 1,
  localparam int CHW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [CHW-1:0]   i_chan,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [CHW-1:0]   o_chan,
  output logic [WIDTH-1:0] o_data
);
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][CHW-1:0]   chan_pipe;
  logic [STAGES:0][WIDTH-1:0] data_pipe;

  assign vld_pipe[0]  = i_valid;
  assign chan_pipe[0] = i_chan;
  assign data_pipe[0] = i_data;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    cic_comb_stage #(
      .WIDTH(WIDTH), .DIFF_DELAY(DIFF_DELAY), .CHANNELS(CHANNELS), .CHW(CHW)
    ) u_stage (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (i_en),
      .i_valid(vld_pipe[g]),
      .i_chan (chan_pipe[g]),
      .i_data (data_pipe[g]),
      .o_valid(vld_pipe[g+1]),
      .o_chan (chan_pipe[g+1]),
      .o_data (data_pipe[g+1])
    );
  end

  assign o_valid = vld_pipe[STAGES];
  assign o_chan  = chan_pipe[STAGES];
  assign o_data  = data_pipe[STAGES];
endmodule
